digit_scan_controller: RTL and testbench

//  Time-multiplexed scan sequencer for the 4-digit seven-segment voltmeter display.

---
 rtl/digit_scan_controller.sv | 144 ++++++++++++++
 tb/tb_digit_scan_controller.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/digit_scan_controller.sv
`default_nettype none
// ============================================================================
//  Module   : digit_scan_controller
//  Brief    : 4-digit seven-segment scan sequencer with tear-free BCD shadow
//             and frame-aligned load handshake. Optional leading-zero blanking
//             is enabled by defining LEADING_ZERO_BLANK_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module digit_scan_controller #(
  parameter int TICK_DIV = 50000,
  parameter int CNT_W    = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       enable_i,
  input  logic       load_i,
  input  logic [3:0] digit1_i,
  input  logic [3:0] digit2_i,
  input  logic [3:0] digit3_i,
  input  logic [3:0] digit4_i,
  output logic [2:0] state_o,
  output logic [3:0] current_digit_o,
  output logic [3:0] anode_o,
  output logic       load_ack_o,
  output logic       frame_o
);

  typedef enum logic [2:0] {
    S0 = 3'b000,
    S1 = 3'b001,
    S2 = 3'b011,
    S3 = 3'b100
  } state_t;

  localparam logic [CNT_W-1:0] c_div_last = CNT_W'(TICK_DIV - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_div;
  logic [15:0]      r_shadow;   // {digit1, digit2, digit3, digit4}
  logic [15:0]      r_staging;
  logic             r_pending;
  logic             r_ack;
  logic             r_frame;

  logic [15:0]      w_incoming;
  logic             w_tick;
  logic             w_commit_slot;
  logic             w_commit;
  logic             w_blank_s1;
  logic             w_blank_s2;
  logic             w_blank_s3;
  logic [3:0]       w_digit;
  logic [3:0]       w_anode;

  assign w_incoming    = {digit1_i, digit2_i, digit3_i, digit4_i};
  assign w_tick        = enable_i && (r_div == c_div_last);
  // Shadow may only change at a frame boundary or while the display is blank.
  assign w_commit_slot = (w_tick && (r_state == S3)) || !enable_i;
  assign w_commit      = w_commit_slot && (load_i || r_pending);

`ifdef LEADING_ZERO_BLANK_EN
  assign w_blank_s3 = (r_shadow[15:12] == 4'd0);
  assign w_blank_s2 = w_blank_s3 && (r_shadow[11:8] == 4'd0);
  assign w_blank_s1 = w_blank_s2 && (r_shadow[7:4] == 4'd0);
`else
  assign w_blank_s3 = 1'b0;
  assign w_blank_s2 = 1'b0;
  assign w_blank_s1 = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= S0;
      r_div     <= '0;
      r_shadow  <= '0;
      r_staging <= '0;
      r_pending <= 1'b0;
      r_ack     <= 1'b0;
      r_frame   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (enable_i) begin
        r_div <= w_tick ? '0 : r_div + CNT_W'(1);
      end
      if (load_i && !w_commit_slot) begin
        r_staging <= w_incoming;
        r_pending <= 1'b1;
      end else if (w_commit) begin
        r_pending <= 1'b0;
      end
      // A load arriving in the commit cycle bypasses staging.
      if (w_commit) begin
        r_shadow <= load_i ? w_incoming : r_staging;
      end
      r_ack   <= w_commit;
      r_frame <= w_tick && (r_state == S3);
    end
  end

  always_comb begin
    w_state_nxt = S0;
    w_digit     = 4'd0;
    w_anode     = 4'b1111;
    case (r_state)
      S0: begin
        w_state_nxt = w_tick ? S1 : S0;
        w_digit     = r_shadow[3:0];
        w_anode     = 4'b1110;
      end
      S1: begin
        w_state_nxt = w_tick ? S2 : S1;
        w_digit     = r_shadow[7:4];
        w_anode     = w_blank_s1 ? 4'b1111 : 4'b1101;
      end
      S2: begin
        w_state_nxt = w_tick ? S3 : S2;
        w_digit     = r_shadow[11:8];
        w_anode     = w_blank_s2 ? 4'b1111 : 4'b1011;
      end
      S3: begin
        w_state_nxt = w_tick ? S0 : S3;
        w_digit     = r_shadow[15:12];
        w_anode     = w_blank_s3 ? 4'b1111 : 4'b0111;
      end
      default: begin
        w_state_nxt = S0;
        w_digit     = 4'd0;
        w_anode     = 4'b1111;
      end
    endcase
    if (!enable_i) begin
      w_anode = 4'b1111;
    end
  end

  assign state_o         = r_state;
  assign current_digit_o = w_digit;
  assign anode_o         = w_anode;
  assign load_ack_o      = r_ack;
  assign frame_o         = r_frame;

endmodule
`default_nettype wire

// File: tb/tb_digit_scan_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_digit_scan_controller
//  Brief    : Directed plus random bench for digit_scan_controller against a
//             position-counting reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_digit_scan_controller;

  localparam int TD    = 4;
  localparam int FRAME = 4 * TD;

  logic       clk = 1'b0;
  logic       rst_i, enable_i, load_i;
  logic [3:0] digit1_i, digit2_i, digit3_i, digit4_i;
  logic [2:0] state_o;
  logic [3:0] current_digit_o, anode_o;
  logic       load_ack_o, frame_o;

  digit_scan_controller #(.TICK_DIV(TD), .CNT_W(16)) dut (
    .clk_i(clk), .rst_i(rst_i), .enable_i(enable_i), .load_i(load_i),
    .digit1_i(digit1_i), .digit2_i(digit2_i), .digit3_i(digit3_i), .digit4_i(digit4_i),
    .state_o(state_o), .current_digit_o(current_digit_o), .anode_o(anode_o),
    .load_ack_o(load_ack_o), .frame_o(frame_o)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int dut_acks = 0;

  // Model: position within the frame in enabled clocks; slot = position / TD.
  int          m_pos;
  logic [15:0] m_sh, m_st;
  logic        m_pend, m_ack, m_frame, m_en;
  logic [2:0]  codes [4] = '{3'b000, 3'b001, 3'b011, 3'b100};

  function automatic int slot();
    return m_pos / TD;
  endfunction

  function automatic logic [3:0] exp_anode();
    int s;
    s = slot();
    if (!m_en) return 4'b1111;
`ifdef LEADING_ZERO_BLANK_EN
    if (s > 0 && ((m_sh >> (4 * s)) == 16'd0)) return 4'b1111;
`endif
    return ~(4'b0001 << s);
  endfunction

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic e, input logic l, input logic [15:0] d);
    logic boundary, cslot;
    rst_i = r; enable_i = e; load_i = l;
    {digit1_i, digit2_i, digit3_i, digit4_i} = d;
    boundary = e && (m_pos == FRAME - 1);
    cslot    = boundary || !e;
    m_en     = e;
    if (r) begin
      m_pos = 0; m_sh = '0; m_st = '0; m_pend = 0; m_ack = 0; m_frame = 0;
    end else begin
      m_ack = 0;
      if (l) begin
        if (cslot) begin m_sh = d; m_pend = 0; m_ack = 1; end
        else begin m_st = d; m_pend = 1; end
      end else if (cslot && m_pend) begin
        m_sh = m_st; m_pend = 0; m_ack = 1;
      end
      m_frame = boundary;
      if (e) m_pos = (m_pos + 1) % FRAME;
    end
    @(posedge clk);
    #1;
    if (load_ack_o === 1'b1) dut_acks++;
    chk("state", {1'b0, state_o}, {1'b0, codes[slot()]});
    chk("digit", current_digit_o, m_sh[4*slot() +: 4]);
    chk("anode", anode_o, exp_anode());
    chk("ack", {3'b0, load_ack_o}, {3'b0, m_ack});
    chk("frame", {3'b0, frame_o}, {3'b0, m_frame});
  endtask

  task automatic run_to_slot(input int s);
    int n;
    n = 0;
    while (slot() != s && n < 4 * FRAME) begin
      step(0, 1, 0, 16'h0);
      n++;
    end
    chk("reach_state", {1'b0, state_o}, {1'b0, codes[s]});
  endtask

  initial begin
    int a0;
    int n;
    rst_i = 1; enable_i = 1; load_i = 0;
    digit1_i = 0; digit2_i = 0; digit3_i = 0; digit4_i = 0;
    m_pos = 0; m_sh = '0; m_st = '0; m_pend = 0; m_ack = 0; m_frame = 0; m_en = 1;

    // Reset state
    step(1, 1, 0, 16'h0);
    chk("rst_state", {1'b0, state_o}, 4'b0000);
`ifndef LEADING_ZERO_BLANK_EN
    chk("rst_anode", anode_o, 4'b1110);
`endif
    chk("rst_ack", {3'b0, load_ack_o}, 4'b0000);

    // First digit advance after TICK_DIV clocks
    repeat (TD) step(0, 1, 0, 16'h0);
    chk("s1_state", {1'b0, state_o}, 4'b0001);
`ifndef LEADING_ZERO_BLANK_EN
    chk("s1_anode", anode_o, 4'b1101);
`endif

    // Load mid-frame: shadow must not change until the frame boundary
    step(0, 1, 1, 16'h1234);
    n = 0;
    while (!frame_o && n < 2 * FRAME) begin
      step(0, 1, 0, 16'h0);
      n++;
    end
    chk("bnd_frame", {3'b0, frame_o}, 4'b0001);
    chk("bnd_ack", {3'b0, load_ack_o}, 4'b0001);
    chk("bnd_digit4", current_digit_o, 4'h4);

    // Disable in S2: blank and hold, then resume with a full slot remaining
    run_to_slot(2);
    repeat (10) step(0, 0, 0, 16'h0);
    chk("dis_anode", anode_o, 4'b1111);
    chk("dis_state", {1'b0, state_o}, 4'b0011);
    repeat (TD - 1) step(0, 1, 0, 16'h0);
    chk("resume_hold", {1'b0, state_o}, 4'b0011);
    step(0, 1, 0, 16'h0);
    chk("resume_adv", {1'b0, state_o}, 4'b0100);

    // Two loads before the boundary: last wins, one ack
    a0 = dut_acks;
    step(0, 1, 1, 16'h5678);
    step(0, 1, 1, 16'h9999);
    repeat (FRAME) step(0, 1, 0, 16'h0);
    chk("dbl_acks", 4'(dut_acks - a0), 4'd1);
    chk("dbl_digit", current_digit_o, 4'h9);

    // Reset with a pending load: load discarded, no ack
    run_to_slot(3);
    step(0, 1, 1, 16'hABCD);
    step(1, 1, 0, 16'h0);
    a0 = dut_acks;
    repeat (2 * FRAME) step(0, 1, 0, 16'h0);
    chk("rstpend_acks", 4'(dut_acks - a0), 4'd0);
    chk("rstpend_digit", current_digit_o, 4'h0);

    // Leading zeros in shadow exercise blanking when that feature is built in
    step(0, 0, 1, 16'h0042);
    repeat (FRAME) step(0, 1, 0, 16'h0);

    // Random traffic
    repeat (600) begin
      step(($urandom % 100) == 0, ($urandom % 8) != 0, ($urandom % 6) == 0,
           (($urandom % 3) == 0) ? 16'($urandom % 256) : 16'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
